// File: rtl/snow64_bfloat16_vec_mul_seq_if.sv
// Handshake bundle between the vector issue logic / scalar multiplier and the lane sequencer.
// master is the environment (command source plus multiplier), slave is the sequencer.
interface snow64_bfloat16_vec_mul_seq_if #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 16
);
  localparam int VEC_WIDTH = NUM_LANES * LANE_WIDTH;

  logic                   in_start;
  logic [VEC_WIDTH-1:0]   in_a;
  logic [VEC_WIDTH-1:0]   in_b;
  logic [NUM_LANES-1:0]   in_lane_mask;
  logic                   in_b_broadcast;
  logic                   out_can_accept_cmd;
  logic                   out_data_valid;
  logic [VEC_WIDTH-1:0]   out_data;
  logic                   mul_start;
  logic [LANE_WIDTH-1:0]  mul_a;
  logic [LANE_WIDTH-1:0]  mul_b;
  logic                   mul_data_valid;
  logic                   mul_can_accept_cmd;
  logic [LANE_WIDTH-1:0]  mul_data;

  modport master (
    output in_start, in_a, in_b, in_lane_mask, in_b_broadcast,
    output mul_data_valid, mul_can_accept_cmd, mul_data,
    input  out_can_accept_cmd, out_data_valid, out_data,
    input  mul_start, mul_a, mul_b
  );

  modport slave (
    input  in_start, in_a, in_b, in_lane_mask, in_b_broadcast,
    input  mul_data_valid, mul_can_accept_cmd, mul_data,
    output out_can_accept_cmd, out_data_valid, out_data,
    output mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/snow64_bfloat16_vec_mul_seq.sv
// Issues the active bfloat16 lanes of one vector op to a scalar multiplier and gathers the products.
// Latency: 1 cycle per skipped lane, issue + multiplier response per active lane, +1; stalls while the multiplier is busy.
module snow64_bfloat16_vec_mul_seq #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  snow64_bfloat16_vec_mul_seq_if.slave  bus
);
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam int VEC_WIDTH  = NUM_LANES * LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic [LANE_IDX_W-1:0]   lane;
  logic [NUM_LANES-1:0]    mask_q;
  logic [LANE_WIDTH-1:0]   a_q   [NUM_LANES];
  logic [LANE_WIDTH-1:0]   b_q   [NUM_LANES];
  logic [LANE_WIDTH-1:0]   res_q [NUM_LANES];
  logic                    wait_first;
  logic                    can_accept_q;
  logic                    data_valid_q;
  logic                    mul_start_q;
  logic [LANE_WIDTH-1:0]   mul_a_q;
  logic [LANE_WIDTH-1:0]   mul_b_q;
  logic [VEC_WIDTH-1:0]    res_flat;

  wire last_lane = (lane == LANE_IDX_W'(NUM_LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lane         <= '0;
      mask_q       <= '0;
      wait_first   <= 1'b0;
      can_accept_q <= 1'b1;
      data_valid_q <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      mul_start_q  <= 1'b0;
      data_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_start) begin
            // Result starts as A so skipped lanes pass A through untouched.
            for (int i = 0; i < NUM_LANES; i++) begin
              a_q[i]   <= bus.in_a[i*LANE_WIDTH +: LANE_WIDTH];
              res_q[i] <= bus.in_a[i*LANE_WIDTH +: LANE_WIDTH];
              b_q[i]   <= bus.in_b_broadcast ? bus.in_b[LANE_WIDTH-1:0]
                                             : bus.in_b[i*LANE_WIDTH +: LANE_WIDTH];
            end
            mask_q       <= bus.in_lane_mask;
            lane         <= '0;
            can_accept_q <= 1'b0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mask_q[lane]) begin
            if (last_lane) state <= DONE;
            else           lane  <= lane + LANE_IDX_W'(1);
          end else if (bus.mul_can_accept_cmd) begin
            mul_start_q <= 1'b1;
            mul_a_q     <= a_q[lane];
            mul_b_q     <= b_q[lane];
            wait_first  <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // The multiplier's valid flag is still the previous result until it sees our start.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (bus.mul_data_valid) begin
            res_q[lane] <= bus.mul_data;
            if (last_lane) begin
              state <= DONE;
            end else begin
              lane  <= lane + LANE_IDX_W'(1);
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          data_valid_q <= 1'b1;
          can_accept_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    res_flat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      res_flat[i*LANE_WIDTH +: LANE_WIDTH] = res_q[i];
    end
  end

  assign bus.out_can_accept_cmd = can_accept_q;
  assign bus.out_data_valid     = data_valid_q;
  assign bus.out_data           = res_flat;
  assign bus.mul_start          = mul_start_q;
  assign bus.mul_a              = mul_a_q;
  assign bus.mul_b              = mul_b_q;
endmodule

// File: tb/tb_snow64_bfloat16_vec_mul_seq.sv
// Bench for the vector multiply sequencer: behavioural bfloat16 multiplier that answers on the
// edge it samples mul_start, plus a result scoreboard checked on every out_data_valid.
module tb_snow64_bfloat16_vec_mul_seq;
  localparam int NL  = 16;
  localparam int LWD = 16;
  localparam int VW  = NL * LWD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snow64_bfloat16_vec_mul_seq_if #(.NUM_LANES(NL), .LANE_WIDTH(LWD)) bus();
  snow64_bfloat16_vec_mul_seq #(.NUM_LANES(NL), .LANE_WIDTH(LWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [8:0]  e;
    logic [6:0]  m;
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {a[15] ^ b[15], 15'd0};
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    e = {1'b0, a[14:7]} + {1'b0, b[14:7]} - 9'd127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 9'd1;
    end else begin
      m = p[13:7];
    end
    return {a[15] ^ b[15], e[7:0], m};
  endfunction

  function automatic logic [VW-1:0] rep(input logic [15:0] v);
    return {NL{v}};
  endfunction

  // Multiplier model: sticky valid, untouched by the sequencer's reset.
  logic        mul_rdy;
  logic        mock_vld = 1'b0;
  logic [15:0] mock_dat = 16'd0;
  assign bus.mul_can_accept_cmd = mul_rdy;
  assign bus.mul_data_valid     = mock_vld;
  assign bus.mul_data           = mock_dat;
  always @(posedge clk) begin
    if (bus.mul_start) begin
      mock_vld <= 1'b1;
      mock_dat <= bf16_mul(bus.mul_a, bus.mul_b);
    end
  end

  int            cyc = 0;
  int            start_cyc = 0, last_lat = 0, n_pulse = 0, n_valid = 0;
  int            acc_bad = 0, b_bad = 0, stall_bad = 0, lane3_issues = 0;
  logic          in_flight = 1'b0, chk_b = 1'b0, rdy_at_edge = 1'b1;
  logic [15:0]   lane3_a = 16'hFFFF;
  logic [VW-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rdy_at_edge <= mul_rdy;
  end

  always @(negedge clk) begin
    if (bus.mul_start) begin
      n_pulse++;
      if (chk_b && bus.mul_b !== 16'h4000) b_bad++;
      if (!rdy_at_edge) stall_bad++;
      if (bus.mul_a === lane3_a) lane3_issues++;
    end
    if (in_flight && bus.out_can_accept_cmd && !bus.out_data_valid) acc_bad++;
    if (bus.out_data_valid) begin
      n_valid++;
      in_flight = 1'b0;
      last_lat  = cyc - start_cyc;
      check("valid_has_pending_expectation", VW'(exp_q.size() != 0), VW'(1));
      if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  task automatic start_cmd(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [15:0] m,
                           input logic bc, input logic [VW-1:0] exp);
    @(negedge clk);
    bus.in_a           = a;
    bus.in_b           = b;
    bus.in_lane_mask   = m;
    bus.in_b_broadcast = bc;
    bus.in_start       = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start_cyc    = cyc;
    in_flight    = 1'b1;
    bus.in_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && in_flight; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_completed"}, VW'(in_flight), VW'(0));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_can_accept"}, VW'(bus.out_can_accept_cmd), VW'(1));
    check({tag, "_data_valid"}, VW'(bus.out_data_valid), VW'(0));
    check({tag, "_out_data"}, bus.out_data, VW'(0));
    check({tag, "_mul_start"}, VW'(bus.mul_start), VW'(0));
    check({tag, "_mul_a"}, VW'(bus.mul_a), VW'(0));
    check({tag, "_mul_b"}, VW'(bus.mul_b), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] a_v, b_v, e_v;
    int p0, v0, bound;

    rst = 1'b1;
    bus.in_start = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_lane_mask = '0;
    bus.in_b_broadcast = 1'b0;
    mul_rdy = 1'b1;
    #1;
    check_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full mask, 1.0 * 2.0 in every lane.
    p0 = n_pulse;
    acc_bad = 0;
    start_cmd(rep(16'h3F80), rep(16'h4000), 16'hFFFF, 1'b0, rep(16'h4000));
    wait_done(100, "full");
    check("full_pulses", VW'(n_pulse - p0), VW'(16));
    check("full_latency", VW'(last_lat), VW'(49));
    check("full_busy_accept", VW'(acc_bad), VW'(0));

    // Broadcast lane 0 of B.
    p0 = n_pulse;
    b_bad = 0;
    chk_b = 1'b1;
    b_v = '0;
    b_v[15:0] = 16'h4000;
    start_cmd(rep(16'h4040), b_v, 16'hFFFF, 1'b1, rep(16'h40C0));
    wait_done(100, "bcast");
    chk_b = 1'b0;
    check("bcast_mul_b", VW'(b_bad), VW'(0));
    check("bcast_pulses", VW'(n_pulse - p0), VW'(16));

    // Partial mask on lanes 4-7.
    e_v = rep(16'h3F80);
    for (int i = 4; i < 8; i++) e_v[i*16 +: 16] = 16'h4000;
    p0 = n_pulse;
    start_cmd(rep(16'h3F80), rep(16'h4000), 16'h00F0, 1'b0, e_v);
    wait_done(100, "partial");
    check("partial_pulses", VW'(n_pulse - p0), VW'(4));
    check("partial_latency", VW'(last_lat), VW'(25));

    // Empty mask, plus an in_start while busy that must be dropped.
    for (int i = 0; i < NL; i++) a_v[i*16 +: 16] = 16'h1000 + 16'(i);
    p0 = n_pulse;
    v0 = n_valid;
    start_cmd(a_v, rep(16'h4000), 16'h0000, 1'b0, a_v);
    repeat (3) @(negedge clk);
    bus.in_a = rep(16'hDEAD);
    bus.in_lane_mask = 16'hFFFF;
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    wait_done(60, "zero");
    check("zero_pulses", VW'(n_pulse - p0), VW'(0));
    check("zero_latency", VW'(last_lat), VW'(17));
    repeat (25) @(negedge clk);
    #1;
    check("zero_single_valid", VW'(n_valid - v0), VW'(1));
    check("zero_data_held", bus.out_data, a_v);

    // Multiplier stall at lane 3.
    for (int i = 0; i < NL; i++) begin
      a_v[i*16 +: 16] = 16'h3F80 + 16'(i << 7);
      e_v[i*16 +: 16] = 16'h4000 + 16'(i << 7);
    end
    lane3_a = 16'h4100;
    lane3_issues = 0;
    stall_bad = 0;
    p0 = n_pulse;
    start_cmd(a_v, rep(16'h4000), 16'hFFFF, 1'b0, e_v);
    bound = 0;
    while (n_pulse - p0 < 3 && bound < 40) begin
      @(negedge clk);
      #1;
      bound++;
    end
    check("stall_reached_lane3", VW'(n_pulse - p0), VW'(3));
    mul_rdy = 1'b0;
    repeat (5) @(negedge clk);
    mul_rdy = 1'b1;
    wait_done(100, "stall");
    check("stall_no_start_while_busy", VW'(stall_bad), VW'(0));
    check("stall_lane3_once", VW'(lane3_issues), VW'(1));
    check("stall_pulses", VW'(n_pulse - p0), VW'(16));
    check("stall_latency", VW'(last_lat), VW'(52));
    lane3_a = 16'hFFFF;

    // Async reset in WAIT of lane 7, then a command that must skip the stale valid.
    p0 = n_pulse;
    start_cmd(rep(16'h3F80), rep(16'h4000), 16'hFFFF, 1'b0, rep(16'h4000));
    bound = 0;
    while (n_pulse - p0 < 8 && bound < 60) begin
      @(negedge clk);
      #1;
      bound++;
    end
    check("rst_reached_lane7", VW'(n_pulse - p0), VW'(8));
    rst = 1'b1;
    #1;
    check_reset("midop_reset");
    exp_q.delete();
    in_flight = 1'b0;
    v0 = n_valid;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midop_no_valid", VW'(n_valid - v0), VW'(0));
    check("stale_flag_present", VW'(bus.mul_data_valid), VW'(1));
    start_cmd(rep(16'h4040), rep(16'h4000), 16'hFFFF, 1'b0, rep(16'h40C0));
    wait_done(100, "after_rst");
    check("after_rst_latency", VW'(last_lat), VW'(49));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/snow64_bfloat16_vec_mul_seq.md
Name: snow64_bfloat16_vec_mul_seq

Overview:
- Upstream sequencer for the scalar BFloat16 multiplier. Takes one 256-bit vector operation (16 lanes of bfloat16) and issues the lanes one at a time to the scalar multiplier.
- Collects the per-lane products into a 256-bit result.
- Sits between the vector ALU issue logic and the multiplier; the multiplier is instantiated outside this block and connected through the mul_* ports.

Parameters:
- NUM_LANES, 16, bfloat16 lanes per vector; lane i occupies bits [16*i+15:16*i].
- LANE_WIDTH, 16, bits per lane; fixed at 16, present for width arithmetic only.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_start  in  1  start a vector multiply; sampled only while out_can_accept_cmd=1.
- in_a  in  256  vector operand A.
- in_b  in  256  vector operand B.
- in_lane_mask  in  16  bit i=1: lane i is multiplied; bit i=0: lane i is skipped.
- in_b_broadcast  in  1  when 1, lane 0 of in_b is used as B for every lane.
- out_can_accept_cmd  out  1  high only in IDLE.
- out_data_valid  out  1  one-cycle pulse when out_data holds a completed result.
- out_data  out  256  result vector; held until the next accepted command.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  16  lane operand A to the multiplier.
- mul_b  out  16  lane operand B to the multiplier.
- mul_data_valid  in  1  multiplier result valid; sticky, cleared by the multiplier on the edge that samples mul_start.
- mul_can_accept_cmd  in  1  multiplier ready.
- mul_data  in  16  multiplier result.

Behaviour:
- Reset (async, any state): state=IDLE, lane counter=0, all captured registers=0.
  - Output values under reset: out_can_accept_cmd=1, out_data_valid=0, out_data=0, mul_start=0, mul_a=0, mul_b=0.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - When in_start=1, capture in_a, in_b (broadcast already applied), in_lane_mask, set lane=0, go to ISSUE.
  - out_data is preloaded with in_a on the same edge.
- ISSUE, lane k:
  - If mask[k]=0: lane k of out_data keeps A's value (merge). Then if k==NUM_LANES-1 go to DONE, else lane=k+1 and stay in ISSUE. Cost: 1 cycle, no mul_start.
  - If mask[k]=1 and mul_can_accept_cmd=1: drive mul_start=1 with mul_a=A[k] and mul_b=B[k] (B[0] when broadcast) for exactly one cycle, then go to WAIT.
  - If mask[k]=1 and mul_can_accept_cmd=0: stall in ISSUE with mul_start=0.
- WAIT:
  - Ignore mul_data_valid on the first cycle after the start pulse (guards the stale sticky flag).
  - Afterwards, when mul_data_valid=1: write mul_data into lane k of out_data. Then if k==NUM_LANES-1 go to DONE, else lane=k+1 and go to ISSUE.
  - No timeout.
- DONE: out_data_valid=1 for one cycle, then IDLE. out_can_accept_cmd returns to 1 on the same edge that enters IDLE.
- Latency from the in_start sample to the out_data_valid pulse:
  - Sum over lanes: 1 cycle per skipped lane; per active lane, 1 issue cycle plus the multiplier's response cycles.
  - With the 2-cycle multiplier, an active lane costs 3 cycles. All 16 active: 48+1 cycles. Mask=0: 16+1 cycles.
- in_start while not IDLE is ignored; no queueing. in_a, in_b and mask may change freely after acceptance.
- The lane counter is 4 bits and never wraps past NUM_LANES-1; DONE is entered from the last lane.
- Arithmetic is done entirely by the multiplier. This block never alters lane bits, and performs no sign or exponent handling.
- Reset mid-operation aborts immediately: partial out_data is cleared to 0 and no out_data_valid pulse is produced. A pending multiplier result is ignored: the next command's first WAIT discards the stale valid.

Test Plan:
- Full mask: A lanes all 0x3F80 (1.0), B lanes all 0x4000 (2.0), mask=0xFFFF -> exactly 16 mul_start pulses, out_data all lanes 0x4000, out_data_valid one-cycle pulse 49 cycles after start, out_can_accept_cmd low throughout.
- Broadcast: A lane i = 0x4040 (3.0), B lane0=0x4000, other B lanes 0x0000, in_b_broadcast=1 -> every mul_b=0x4000, all out lanes 0x40C0.
- Partial mask: mask=0x00F0, A=0x3F80, B=0x4000 -> 4 mul_start pulses on lanes 4-7; out lanes 4-7=0x4000, others 0x3F80; latency 12+12+1=25 cycles.
- Mask zero -> no mul_start, out_data==in_a, valid pulse 17 cycles after start; in_start pulsed while busy is ignored, with no second pulse.
- Stall: hold mul_can_accept_cmd=0 for 5 cycles at lane 3 -> mul_start withheld, lane 3 issued once when ready rises, final result correct.
- Async rst asserted in WAIT of lane 7 -> outputs go to reset values without a clock edge; a following command completes correctly with the stale mul_data_valid ignored.
